// File: rtl/mem_arbiter.sv
// mem_arbiter: shares the single-port SOC Memory between two valid/ready
// requesters (port 0 = CPU, port 1 = aux master). Each accepted request is
// serialised onto the RAM interface. Completion is a one-cycle ready pulse
// that carries the read data and an out-of-range error flag.
// Optional build macro: MEM_ARB_ROUND_ROBIN_EN. When it is defined, a tie goes
// to the port not granted last. When it is undefined, port 0 always wins.
module mem_arbiter #(
    parameter int MEM_WORDS = 1536
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        p0_valid,
    input  logic [31:0] p0_addr,
    input  logic [31:0] p0_wdata,
    input  logic [3:0]  p0_wmask,
    output logic [31:0] p0_rdata,
    output logic        p0_ready,
    output logic        p0_err,
    input  logic        p1_valid,
    input  logic [31:0] p1_addr,
    input  logic [31:0] p1_wdata,
    input  logic [3:0]  p1_wmask,
    output logic [31:0] p1_rdata,
    output logic        p1_ready,
    output logic        p1_err,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_wmask,
    output logic        mem_rstrb,
    input  logic [31:0] mem_rdata
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] ISSUE = 2'd1;
    localparam logic [1:0] RESP  = 2'd2;

    localparam logic [31:0] MEM_WORDS_U = 32'(MEM_WORDS);

    logic [1:0]  state;
    logic        owner;
    logic        err_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [3:0]  wmask_q;

    logic        any_valid;
    logic        grant;
    logic [31:0] win_addr;
    logic [31:0] win_wdata;
    logic [3:0]  win_wmask;
    logic        win_err;
    logic        is_issue;
    logic        is_resp;
    logic [31:0] resp_rdata;

    assign any_valid = p0_valid | p1_valid;

`ifdef MEM_ARB_ROUND_ROBIN_EN
    logic last_grant;

    // On a tie, the port that was not granted last wins. A lone requester always wins.
    always_comb begin
        grant = ~p0_valid;
        if (p0_valid && p1_valid) begin
            grant = ~last_grant;
        end
    end

    // Remember which port won the most recent arbitration
    always_ff @(posedge clk) begin
        if (rst) begin
            last_grant <= 1'b1;
        end else if (state == IDLE && any_valid) begin
            last_grant <= grant;
        end
    end
`else
    // Fixed priority: port 1 only wins when port 0 is not requesting
    always_comb begin
        grant = ~p0_valid;
    end
`endif

    // Select the winner's payload and range-check its word index
    always_comb begin
        win_addr  = grant ? p1_addr  : p0_addr;
        win_wdata = grant ? p1_wdata : p0_wdata;
        win_wmask = grant ? p1_wmask : p0_wmask;
        win_err   = ({2'b00, win_addr[31:2]} >= MEM_WORDS_U);
    end

    // Transaction FSM: latch the winner in IDLE, hit the RAM in ISSUE, and reply in RESP
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            owner   <= 1'b0;
            err_q   <= 1'b0;
            addr_q  <= 32'h0;
            wdata_q <= 32'h0;
            wmask_q <= 4'h0;
        end else begin
            case (state)
                IDLE: begin
                    if (any_valid) begin
                        owner   <= grant;
                        addr_q  <= win_addr;
                        wdata_q <= win_wdata;
                        wmask_q <= win_wmask;
                        err_q   <= win_err;
                        state   <= win_err ? RESP : ISSUE;
                    end
                end
                ISSUE:   state <= RESP;
                RESP:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    assign is_issue = (state == ISSUE);
    assign is_resp  = (state == RESP);

    // RAM strobes only in ISSUE. Address and data hold their last latched values.
    always_comb begin
        mem_addr  = addr_q;
        mem_wdata = wdata_q;
        mem_rstrb = is_issue && !err_q && (wmask_q == 4'h0);
        mem_wmask = (is_issue && !err_q) ? wmask_q : 4'h0;
    end

    // Response decode: only the owner sees ready, and data flows only for in-range reads
    always_comb begin
        resp_rdata = (!err_q && wmask_q == 4'h0) ? mem_rdata : 32'h0;
        p0_ready   = is_resp && !owner;
        p1_ready   = is_resp && owner;
        p0_rdata   = p0_ready ? resp_rdata : 32'h0;
        p1_rdata   = p1_ready ? resp_rdata : 32'h0;
        p0_err     = p0_ready && err_q;
        p1_err     = p1_ready && err_q;
    end

endmodule
